// File: rtl/mul_product_accumulator.sv
// Product-stream accumulator: sums packets of 2N-bit multiplier products
// (signed or unsigned per beat) into an ACC_W-bit sum. One result beat
// carrying sum, beat count, overflow and mixed-mode error is emitted per packet.
module mul_product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  input  logic             in_sign,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int PW = 2*N;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Registered state
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               pkt_sign_q, pkt_sign_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_err_q, out_err_d;

  // Per-beat datapath
  logic signed [PW-1:0] prod_s;
  logic [ACC_W-1:0]     ext;
  logic [ACC_W:0]       sum_full;
  logic [ACC_W-1:0]     sum_n;
  logic                 carry;
  logic                 first_beat;
  logic                 mode_sign;
  logic                 beat_ovf;
  logic [CNT_W-1:0]     count_inc;
  logic                 ovf_n;
  logic                 err_n;
  logic                 accept;

  // Ready depends only on state so upstream never sees a combinational loop
  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // Extend the beat, add it, and work out the updated packet statistics
  always_comb begin
    prod_s     = in_prod;
    ext        = in_sign ? ACC_W'(prod_s) : ACC_W'(in_prod);
    sum_full   = {1'b0, acc_q} + {1'b0, ext};
    sum_n      = sum_full[ACC_W-1:0];
    carry      = sum_full[ACC_W];
    first_beat = (count_q == '0);
    // The first beat defines the packet's mode before pkt_sign is written
    mode_sign  = first_beat ? in_sign : pkt_sign_q;
    if (mode_sign) begin
      beat_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum_n[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      beat_ovf = carry;
    end
    count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
    ovf_n     = ovf_q | beat_ovf;
    err_n     = err_q | (!first_beat && (in_sign != pkt_sign_q));
  end

  // Next-state logic: accumulate in ACCUM, publish on last beat, drain in HOLD
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    pkt_sign_d  = pkt_sign_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (first_beat) begin
            pkt_sign_d = in_sign;
          end
          if (in_last) begin
            out_sum_d   = sum_n;
            out_count_d = count_inc;
            out_ovf_d   = ovf_n;
            out_err_d   = err_n;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d   = sum_n;
            count_d = count_inc;
            ovf_d   = ovf_n;
            err_d   = err_n;
          end
        end
      end
      HOLD: begin
        // Data outputs keep their values after the handshake
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers with synchronous active-low reset discarding any packet or held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      pkt_sign_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      pkt_sign_q  <= pkt_sign_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench for mul_product_accumulator with N=4, ACC_W=12, CNT_W=8.
module tb_mul_product_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_prod;
  logic             in_sign;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_err;

  int n_vec  = 0;
  int n_fail = 0;

  mul_product_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_sign(in_sign), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  prod;
    logic        sign;
    int          reps;
    logic        last;
    logic [11:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
    logic        err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait (bounded) until it is taken
  task automatic send_beat(input logic [7:0] p, input logic s, input logic l);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_sign  = s;
    in_last  = l;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check("in_ready_at_accept", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic check_result(input string tag, input logic [11:0] sum, input logic [7:0] cnt,
                              input logic ovf, input logic err);
    $display("result %s: valid=%0b sum=0x%03h count=%0d ovf=%0b err=%0b",
             tag, out_valid, out_sum, out_count, out_ovf, out_err);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(in_ready),  32'd0);
    check({tag, ".out_sum"},   32'(out_sum),   32'(sum));
    check({tag, ".out_count"}, 32'(out_count), 32'(cnt));
    check({tag, ".out_ovf"},   32'(out_ovf),   32'(ovf));
    check({tag, ".out_err"},   32'(out_err),   32'(err));
  endtask

  task automatic handshake(input string tag, input logic [11:0] sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".hs_valid_low"}, 32'(out_valid), 32'd0);
    check({tag, ".hs_ready_high"}, 32'(in_ready), 32'd1);
    check({tag, ".hs_sum_kept"}, 32'(out_sum), 32'(sum));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_sum"},   32'(out_sum),   32'd0);
    check({tag, ".out_count"}, 32'(out_count), 32'd0);
    check({tag, ".out_ovf"},   32'(out_ovf),   32'd0);
    check({tag, ".out_err"},   32'(out_err),   32'd0);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // prod, sign, reps, last, sum, count, ovf, err
    vecs[0]  = '{8'hC8, 1'b1, 1,   1'b0, 12'h000, 8'd0,   1'b0, 1'b0};
    vecs[1]  = '{8'hC8, 1'b1, 1,   1'b0, 12'h000, 8'd0,   1'b0, 1'b0};
    vecs[2]  = '{8'h40, 1'b1, 1,   1'b1, 12'hFD0, 8'd3,   1'b0, 1'b0};
    vecs[3]  = '{8'hE1, 1'b0, 1,   1'b0, 12'h000, 8'd0,   1'b0, 1'b0};
    vecs[4]  = '{8'hE1, 1'b0, 1,   1'b1, 12'h1C2, 8'd2,   1'b0, 1'b0};
    vecs[5]  = '{8'h07, 1'b0, 1,   1'b1, 12'h007, 8'd1,   1'b0, 1'b0};
    vecs[6]  = '{8'hE1, 1'b0, 19,  1'b1, 12'h0B3, 8'd19,  1'b1, 1'b0};
    vecs[7]  = '{8'h01, 1'b0, 1,   1'b1, 12'h001, 8'd1,   1'b0, 1'b0};
    vecs[8]  = '{8'hF0, 1'b1, 1,   1'b0, 12'h000, 8'd0,   1'b0, 1'b0};
    vecs[9]  = '{8'h10, 1'b0, 1,   1'b1, 12'h000, 8'd2,   1'b0, 1'b1};
    // 17 x 127 = 2159 exceeds +2047 in signed mode
    vecs[10] = '{8'h7F, 1'b1, 17,  1'b1, 12'h86F, 8'd17,  1'b1, 1'b0};
    vecs[11] = '{8'h80, 1'b1, 1,   1'b1, 12'hF80, 8'd1,   1'b0, 1'b0};
    // Count saturates at 255 while the sum keeps going (300 = 0x12C)
    vecs[12] = '{8'h01, 1'b0, 300, 1'b1, 12'h12C, 8'd255, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_sign   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Table-driven packets
    for (int v = 0; v < NV; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        send_beat(vecs[v].prod, vecs[v].sign, vecs[v].last && (r == vecs[v].reps - 1));
      end
      in_valid = 1'b0;
      if (vecs[v].last) begin
        check_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].cnt, vecs[v].ovf, vecs[v].err);
        handshake($sformatf("vec%0d", v), vecs[v].sum);
      end else begin
        $display("beat vec%0d: prod=0x%02h sign=%0b accepted, out_valid=%0b",
                 v, vecs[v].prod, vecs[v].sign, out_valid);
        check($sformatf("vec%0d.no_result", v), 32'(out_valid), 32'd0);
      end
    end

    // Backpressure: result held 5 cycles while a new beat waits
    send_beat(8'h33, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_prod  = 8'h10;
    in_sign  = 1'b0;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      $display("stall cycle %0d: in_ready=%0b out_valid=%0b sum=0x%03h", c, in_ready, out_valid, out_sum);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.out_sum",   32'(out_sum),   32'h033);
      check("bp.out_count", 32'(out_count), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.hs_valid_low", 32'(out_valid), 32'd0);
    check("bp.hs_sum_kept",  32'(out_sum),   32'h033);
    tick();
    in_valid = 1'b0;
    check_result("bp_next", 12'h010, 8'd1, 1'b0, 1'b0);
    handshake("bp_next", 12'h010);
    tick();
    tick();
    check("bp.no_duplicate", 32'(out_valid), 32'd0);

    // Reset mid-packet discards the partial sum
    send_beat(8'h20, 1'b0, 1'b0);
    send_beat(8'h20, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("after_mid_reset");
    send_beat(8'h05, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_result("post_reset_pkt", 12'h005, 8'd1, 1'b0, 1'b0);

    // Reset while a result is held drops it without a handshake
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("reset_in_hold");
    tick();
    check("reset_in_hold.stays_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
